muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_pkg.sv | 32 +++
 rtl/muldiv_negate.sv | 13 +
 rtl/muldiv_seq.sv | 171 +++++++++++++++++
 tb/tb_muldiv_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared ISA definitions for the multiply/divide unit: funct codes,
// the decoded op-kind bundle and small funct decode helpers.
package muldiv_pkg;

   localparam logic [5:0] FUN_MTHI  = 6'h11;
   localparam logic [5:0] FUN_MTLO  = 6'h13;
   localparam logic [5:0] FUN_MULT  = 6'h18;
   localparam logic [5:0] FUN_MULTU = 6'h19;
   localparam logic [5:0] FUN_DIV   = 6'h1A;
   localparam logic [5:0] FUN_DIVU  = 6'h1B;

   typedef struct packed {
      logic dv;
      logic sg;
   } mdop_t;

   function automatic logic is_mul(input logic [5:0] f);
      return (f == FUN_MULT) || (f == FUN_MULTU);
   endfunction

   function automatic logic is_div(input logic [5:0] f);
      return (f == FUN_DIV) || (f == FUN_DIVU);
   endfunction

   function automatic mdop_t decode(input logic [5:0] f);
      mdop_t op;
      op.dv = is_div(f);
      op.sg = (f == FUN_MULT) || (f == FUN_DIV);
      return op;
   endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate (combinational).
// Ports: a = value, en = negate when 1, y = result.
module muldiv_negate #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic             en,
   output logic [WIDTH-1:0] y
);

   assign y = en ? (~a + WIDTH'(1)) : a;

endmodule

// File: rtl/muldiv_seq.sv
// Sequential radix-2 MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Ports: clk, rst (sync, active high), start/funct/opA/opB issue,
//   cancel (flush), busy, done (1-cycle pulse), hi, lo.
// Macro MULDIV_DIVIDE_EN: build the DIV/DIVU datapath.
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PREP,
      S_ITER,
      S_FIX
   } state_t;

   state_t state, nxt;

   logic             go_md, cap, prep, iter, fix;
   logic             wr_hi, wr_lo;
   logic [WIDTH-1:0] ra, rb, mc;
   logic [WIDTH-1:0] maga, magb;
   logic [2*WIDTH-1:0] acc, nacc, prod;
   logic [WIDTH:0]   madd;
   logic [CW-1:0]    cnt;
   logic             sg, sa, sb, dv;
   mdop_t            op;

   assign op = decode(funct);

`ifdef MULDIV_DIVIDE_EN
   assign go_md = is_mul(funct) || is_div(funct);
`else
   assign go_md = is_mul(funct);
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         S_IDLE: if (start && go_md) nxt = S_PREP;
         S_PREP: nxt = S_ITER;
         S_ITER: if (cnt == CW'(WIDTH - 1)) nxt = S_FIX;
         S_FIX:  nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
      if (cancel && state != S_IDLE) nxt = S_IDLE;
   end

   always_comb begin
      busy  = (state != S_IDLE);
      cap   = (state == S_IDLE) && start && go_md;
      wr_hi = (state == S_IDLE) && start && (funct == FUN_MTHI);
      wr_lo = (state == S_IDLE) && start && (funct == FUN_MTLO);
      prep  = (state == S_PREP);
      iter  = (state == S_ITER);
      fix   = (state == S_FIX) && !cancel;
   end

   muldiv_negate #(.WIDTH(WIDTH)) u_nega (
      .a(ra), .en(sg & ra[WIDTH-1]), .y(maga)
   );
   muldiv_negate #(.WIDTH(WIDTH)) u_negb (
      .a(rb), .en(sg & rb[WIDTH-1]), .y(magb)
   );
   muldiv_negate #(.WIDTH(2*WIDTH)) u_negp (
      .a(acc), .en(sa ^ sb), .y(prod)
   );

   // Shift-add: upper half accumulates, multiplier bits leave on the right.
   assign madd = {1'b0, acc[2*WIDTH-1:WIDTH]}
               + {1'b0, (acc[0] ? mc : '0)};

`ifdef MULDIV_DIVIDE_EN
   logic [WIDTH:0]   dsh, dsub;
   logic [WIDTH-1:0] quo, rem;
   logic             bz;

   // Restoring step: upper half is the partial remainder,
   // lower half shifts the dividend out and the quotient in.
   assign dsh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign dsub = dsh - {1'b0, mc};

   always_comb begin
      if (!dv)
         nacc = {madd, acc[WIDTH-1:1]};
      else if (dsub[WIDTH])
         nacc = {dsh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
         nacc = {dsub[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
   end

   muldiv_negate #(.WIDTH(WIDTH)) u_negq (
      .a(acc[WIDTH-1:0]), .en(sa ^ sb), .y(quo)
   );
   muldiv_negate #(.WIDTH(WIDTH)) u_negr (
      .a(acc[2*WIDTH-1:WIDTH]), .en(sa), .y(rem)
   );

   always_ff @(posedge clk) begin
      if (cap)  dv <= op.dv;
      if (prep) bz <= (rb == '0);
   end
`else
   assign dv   = 1'b0;
   assign nacc = {madd, acc[WIDTH-1:1]};
`endif

   always_ff @(posedge clk) begin
      if (cap) begin
         ra <= opA;
         rb <= opB;
         sg <= op.sg;
      end
      if (prep) begin
         sa  <= sg & ra[WIDTH-1];
         sb  <= sg & rb[WIDTH-1];
         cnt <= '0;
         acc <= {{WIDTH{1'b0}}, (dv ? maga : magb)};
         mc  <= dv ? magb : maga;
      end
      if (iter) begin
         cnt <= cnt + CW'(1);
         acc <= nacc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hi   <= '0;
         lo   <= '0;
         done <= 1'b0;
      end else begin
         done <= fix;
         if (wr_hi) hi <= opA;
         if (wr_lo) lo <= opA;
         if (fix) begin
            {hi, lo} <= prod;
`ifdef MULDIV_DIVIDE_EN
            if (dv && bz) begin
               lo <= '1;
               hi <= ra;
            end else if (dv) begin
               lo <= quo;
               hi <= rem;
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: vector table plus
// hand sequences for cancel, reset and ignored issues.
module tb_muldiv_seq;
   import muldiv_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst, start, cancel;
   logic [5:0]   funct;
   logic [W-1:0] opA, opB;
   logic         busy, done;
   logic [W-1:0] hi, lo;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       nm;
      logic [5:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] ehi;
      logic [31:0] elo;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   muldiv_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .funct(funct),
      .opA(opA), .opB(opB), .cancel(cancel), .busy(busy),
      .done(done), .hi(hi), .lo(lo)
   );

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic issue(input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b);
      start = 1'b1;
      funct = f;
      opA   = a;
      opB   = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      funct = 6'h00;
   endtask

   task automatic wait_done(inout int n);
      while (!done && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic finish_op(input string nm, input int n0,
                            input logic [31:0] ehi,
                            input logic [31:0] elo);
      int n;
      n = n0;
      wait_done(n);
      chk({nm, "_latency"}, 64'(n), 64'd35);
      chk({nm, "_busy_at_done"}, 64'(busy), 64'd0);
      chk({nm, "_hi"}, 64'(hi), 64'(ehi));
      chk({nm, "_lo"}, 64'(lo), 64'(elo));
      @(posedge clk);
      #1;
      chk({nm, "_done_pulse"}, 64'(done), 64'd0);
   endtask

   task automatic run_op(input vec_t v);
      issue(v.f, v.a, v.b);
      chk({v.nm, "_busy"}, 64'(busy), 64'd1);
      finish_op(v.nm, 1, v.ehi, v.elo);
   endtask

   task automatic expect_idle(input string nm, input logic [31:0] ehi,
                              input logic [31:0] elo);
      int d;
      d = 0;
      chk({nm, "_busy"}, 64'(busy), 64'd0);
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done || busy) d++;
      end
      chk({nm, "_quiet"}, 64'(d), 64'd0);
      chk({nm, "_hi"}, 64'(hi), 64'(ehi));
      chk({nm, "_lo"}, 64'(lo), 64'(elo));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      cancel = 1'b0;
      funct  = 6'h00;
      opA    = '0;
      opB    = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_hi", 64'(hi), 64'd0);
      chk("reset_lo", 64'(lo), 64'd0);
      rst = 1'b0;

      vecs.push_back('{"multu_max", FUN_MULTU, 32'hFFFFFFFF,
                       32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
      vecs.push_back('{"mult_m3x5", FUN_MULT, 32'hFFFFFFFD,
                       32'h5, 32'hFFFFFFFF, 32'hFFFFFFF1});
      vecs.push_back('{"multu_2x3", FUN_MULTU, 32'h2,
                       32'h3, 32'h0, 32'h6});
      vecs.push_back('{"mult_minsq", FUN_MULT, 32'h80000000,
                       32'h80000000, 32'h40000000, 32'h0});
      vecs.push_back('{"mult_7xm1", FUN_MULT, 32'h7,
                       32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9});
      vecs.push_back('{"multu_hix2", FUN_MULTU, 32'h80000000,
                       32'h2, 32'h1, 32'h0});
`ifdef MULDIV_DIVIDE_EN
      vecs.push_back('{"div_m7d2", FUN_DIV, 32'hFFFFFFF9,
                       32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD});
      vecs.push_back('{"divu_by0", FUN_DIVU, 32'h64,
                       32'h0, 32'h64, 32'hFFFFFFFF});
      vecs.push_back('{"div_minm1", FUN_DIV, 32'h80000000,
                       32'hFFFFFFFF, 32'h0, 32'h80000000});
      vecs.push_back('{"divu_100d7", FUN_DIVU, 32'd100,
                       32'd7, 32'd2, 32'd14});
      vecs.push_back('{"div_7dm2", FUN_DIV, 32'd7,
                       32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD});
      vecs.push_back('{"div_m5by0", FUN_DIV, 32'hFFFFFFFB,
                       32'h0, 32'hFFFFFFFB, 32'hFFFFFFFF});
`endif

      foreach (vecs[i]) run_op(vecs[i]);

      // MTHI / MTLO then cancel in ITER cycle 10
      issue(FUN_MTHI, 32'h12345678, 32'h0);
      chk("mthi_busy", 64'(busy), 64'd0);
      chk("mthi_hi", 64'(hi), 64'h12345678);
      issue(FUN_MTLO, 32'h9ABCDEF0, 32'h0);
      chk("mtlo_busy", 64'(busy), 64'd0);
      chk("mtlo_lo", 64'(lo), 64'h9ABCDEF0);
      chk("mtlo_done", 64'(done), 64'd0);
      issue(FUN_MULTU, 32'h3, 32'h4);
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      chk("cancel_iter_pre", 64'(busy), 64'd1);
      cancel = 1'b1;
      @(posedge clk);
      #1;
      cancel = 1'b0;
      expect_idle("cancel_iter", 32'h12345678, 32'h9ABCDEF0);

      // cancel coinciding with FIX
      issue(FUN_MULTU, 32'h5, 32'h5);
      repeat (33) begin
         @(posedge clk);
         #1;
      end
      chk("cancel_fix_pre", 64'(busy), 64'd1);
      cancel = 1'b1;
      @(posedge clk);
      #1;
      cancel = 1'b0;
      expect_idle("cancel_fix", 32'h12345678, 32'h9ABCDEF0);

      // unrecognized funct is ignored
      issue(6'h20, 32'hCAFEF00D, 32'h1);
      expect_idle("bad_funct", 32'h12345678, 32'h9ABCDEF0);

      // start while busy is ignored
      issue(FUN_MULTU, 32'd6, 32'd7);
      issue(FUN_MTHI, 32'hDEADBEEF, 32'h0);
      chk("busy_mthi_hi", 64'(hi), 64'h12345678);
      finish_op("busy_start", 2, 32'h0, 32'd42);

      // reset in ITER cycle 20
      issue(FUN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      repeat (20) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_done", 64'(done), 64'd0);
      chk("midrst_hi", 64'(hi), 64'd0);
      chk("midrst_lo", 64'(lo), 64'd0);
      run_op('{"post_rst", FUN_MULTU, 32'h2, 32'h3, 32'h0, 32'h6});

`ifndef MULDIV_DIVIDE_EN
      issue(FUN_DIVU, 32'd10, 32'd2);
      expect_idle("divu_off", 32'h0, 32'h6);
`endif

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
